// File: rtl/cellrv32_npu_instruction_fifo.sv
// cellrv32_npu_instruction_fifo: assembles 80-bit NPU instructions from CPU word writes and queues them for issue
module cellrv32_npu_instruction_fifo #(
  parameter int DEPTH = 16,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic        clk_i,
  input  logic        rstn_i,
  input  logic        enable_i,
  input  logic        clear_i,
  input  logic        wr_en_i,
  input  logic [1:0]  wr_sel_i,
  input  logic [31:0] wr_data_i,
  input  logic        inst_busy_i,
  output logic [79:0] inst_o,
  output logic        inst_wr_o,
  output logic        full_o,
  output logic        empty_o,
  output logic [AW:0] level_o,
  output logic        overflow_o
);
  localparam logic [AW:0] DEPTH_L = (AW+1)'(DEPTH);
  logic [31:0] word0, word1;
  logic [79:0] mem [DEPTH];
  logic [AW-1:0] wptr, rptr;
  logic [AW:0] level;
  logic commit, issue, pop, push;
  logic [79:0] commit_inst;
  assign full_o      = level == DEPTH_L;
  assign empty_o     = level == '0;
  assign level_o     = level;
  assign commit      = wr_en_i && wr_sel_i == 2'd2;
  assign issue       = enable_i && !inst_busy_i;
  assign pop         = issue && !empty_o && !clear_i;
  assign push        = commit && (!full_o || pop) && !clear_i;
  // word2 supplies opcode and the top byte of buffer_address directly from the bus
  assign commit_inst = {wr_data_i[15:8], word0, word1[15:0], wr_data_i[7:0], word1[31:16]};
  // instruction storage, written on an accepted commit
  always_ff @(posedge clk_i) begin
    if (push) mem[wptr] <= commit_inst;
  end
  // staging, pointers, level, sticky overflow and the issue register
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i || clear_i) begin
      word0      <= '0;
      word1      <= '0;
      wptr       <= '0;
      rptr       <= '0;
      level      <= '0;
      overflow_o <= 1'b0;
      inst_o     <= '0;
      inst_wr_o  <= 1'b0;
    end else begin
      if (wr_en_i && wr_sel_i == 2'd0) word0 <= wr_data_i;
      if (wr_en_i && wr_sel_i == 2'd1) word1 <= wr_data_i;
      if (push) wptr <= wptr + AW'(1);
      if (pop) rptr <= rptr + AW'(1);
      level <= level + (AW+1)'(push) - (AW+1)'(pop);
      if (commit && !push) overflow_o <= 1'b1;
      if (issue) begin
        inst_wr_o <= !empty_o;
        inst_o    <= empty_o ? '0 : mem[rptr];
      end
    end
  end
endmodule

// File: doc/cellrv32_npu_instruction_fifo.md
Name: cellrv32_npu_instruction_fifo

Overview:
- Upstream feeder of the NPU look-ahead buffer.
- Assembles 80-bit NPU instructions from three 32-bit CPU register writes and queues them in a FIFO.
- Issues one instruction per cycle on the inst/wr pair, only while the downstream stage is enabled and not busy.
- Reports fill level, full, empty and a sticky overflow error to the CPU status register.

Parameters:
DEPTH, 16, FIFO entries; power of two, minimum 2.
AW, $clog2(DEPTH), pointer width (derived, not overridable).

Ports:
clk_i  in  1  clock
rstn_i  in  1  reset, asynchronous, active-low
enable_i  in  1  NPU enable; gates issue only
clear_i  in  1  synchronous flush
wr_en_i  in  1  CPU write strobe, one cycle per word
wr_sel_i  in  2  word select: 0, 1, 2; 3 is reserved
wr_data_i  in  32  CPU write data
inst_busy_i  in  1  downstream busy; stalls issue
inst_o  out  80  instruction_t: opcode[7:0], calc_length[31:0], acc_address[15:0], buffer_address[23:0]
inst_wr_o  out  1  instruction-valid to look-ahead buffer
full_o  out  1  FIFO full
empty_o  out  1  FIFO empty
level_o  out  AW+1  entries stored in FIFO memory
overflow_o  out  1  sticky: commit dropped because FIFO was full

Behaviour:
- Reset values: all staging regs, pointers, inst_o = 0 and inst_wr_o = 0; empty_o = 1, full_o = 0, level_o = 0, overflow_o = 0.
- Word mapping:
  - word0: calc_length[31:0].
  - word1[15:0]: acc_address.
  - word1[31:16]: buffer_address[15:0].
  - word2[7:0]: buffer_address[23:16].
  - word2[15:8]: opcode.
  - word2[31:16]: ignored.
- Staging:
  - wr_en_i with sel 0 or 1 latches that word into its staging reg.
  - Staging regs are not cleared after a commit; a repeat instruction needs only a word2 write.
  - sel 3 is ignored.
- Commit: wr_en_i with sel 2 forms the instruction from word2 data (combinational) plus staging word0/word1, and pushes it the same cycle.
  - The entry is visible in memory at t+1.
- Push when full:
  - Accepted if a pop occurs in the same cycle.
  - Otherwise dropped, overflow_o is set, and pointers are unchanged.
- Pop and issue condition: enable_i && !inst_busy_i.
  - On such a cycle: inst_wr_o <= !empty; inst_o <= empty ? 0 : head entry; read pointer advances if not empty.
  - When the condition is false, inst_o and inst_wr_o hold their values. The downstream stage does not sample while busy or disabled, so each instruction is delivered exactly once.
- Latency: commit at cycle t, FIFO entry at t+1, inst_wr_o = 1 at t+2 (with enable_i = 1 and busy = 0 throughout).
- Throughput: back-to-back commits give back-to-back inst_wr_o pulses.
- Simultaneous push and pop on empty FIFO: no bypass. The pushed entry issues on the next eligible cycle.
- Counter arithmetic:
  - Pointers are AW bits and wrap modulo DEPTH.
  - level_o counts 0..DEPTH.
  - full_o = (level == DEPTH); empty_o = (level == 0).
  - level changes: +1 on push only, -1 on pop only, unchanged on push+pop.
- clear_i:
  - Zeroes pointers, level, staging regs, overflow_o, inst_o and inst_wr_o next cycle.
  - Has priority over a write or pop in the same cycle.
- enable_i = 0 still allows CPU pushes; only issue is frozen.
- Reset mid-operation: everything returns to reset values immediately; queued instructions are lost.

Test Plan:
- Single instruction: write word0 = 0x00000010, word1 = 0x3456_0020, word2 = 0x0000_0912 with enable = 1, busy = 0 -> two cycles after the word2 write, inst_wr_o = 1 for one cycle; opcode = 0x09, calc_length = 0x10, acc_address = 0x0020, buffer_address = 0x123456; level_o returns to 0.
- Fill: enable = 0, commit 16 instructions -> full_o = 1, level_o = 16. Commit a 17th -> overflow_o = 1, level_o stays 16. Set enable = 1 -> 16 consecutive inst_wr_o pulses in commit order; empty_o = 1 after the last.
- Busy stall: with 3 queued instructions, hold busy = 1 for 5 cycles mid-stream -> inst_o/inst_wr_o frozen; no instruction lost or duplicated; ordering preserved after release.
- Full push+pop: full FIFO, busy = 0, commit in the same cycle as a pop -> push accepted, overflow_o stays 0, level_o stays 16.
- Wrap-around: 40 instructions with random busy/enable -> output sequence matches input sequence exactly.
- Clear/reset: clear_i asserted during a commit with 5 queued -> next cycle level_o = 0, empty_o = 1, overflow_o = 0, inst_wr_o = 0. Assert rstn_i low mid-stream -> all outputs at reset values immediately.
